alu_multiciclo: RTL and testbench

- Parametrised, handshaked successor to the datapath's single-cycle ALU.
- Same operation encoding and zero flag; operands and results are registered.
- Multiplication runs as a shift-add sequence; division runs as a restoring sequence, so the block meets timing at WIDTH up to 64.
- Sits between operand fetch and writeback; uses valid/ready on both sides, so the control unit stalls on long operations.

---
 rtl/alu_multiciclo.sv | 176 +++++++++++++++++
 tb/tb_alu_multiciclo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: add/sub/logic/compare in one cycle, shift-add multiply, restoring divide.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for MUL/DIV.
// Backpressure: IN_READY only in IDLE; the result is held in DONE until OUT_READY.
// Optional divider: define ALU_DIV_EN to build the DIV state and restoring divider.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A_ALUC,
  input  logic [WIDTH-1:0] B_ALUC,
  input  logic [3:0]       SELECTOR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULTADO,
  output logic             ZF,
  output logic             DZ
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dz_q, dz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  // a: multiplicand (MUL) / dividend shifting into quotient (DIV)
  logic [WIDTH-1:0] a_q, a_d;
  // b: multiplier shifting right (MUL) / divisor (DIV)
  logic [WIDTH-1:0] b_q, b_d;
  // acc: partial product (MUL) / partial remainder (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] mul_sum;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] quo_next;
`endif

  // Single-cycle operations straight from the input operands
  always_comb begin
    simple_res = '0;
    case (SELECTOR)
      4'b0000: simple_res = A_ALUC + B_ALUC;
      4'b0001: simple_res = A_ALUC - B_ALUC;
      4'b0100: simple_res = A_ALUC & B_ALUC;
      4'b0101: simple_res = A_ALUC | B_ALUC;
      4'b0110: simple_res = A_ALUC ^ B_ALUC;
      4'b0111: simple_res = ~(A_ALUC | B_ALUC);
      4'b1000: simple_res = {{(WIDTH-1){1'b0}}, (A_ALUC < B_ALUC)};
      default: simple_res = '0;
    endcase
  end

  // Next-state, datapath step and registered handshake outputs
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_sum  = acc_q + (b_q[0] ? a_q : '0);
`ifdef ALU_DIV_EN
    // Restoring step: bring in the next dividend bit, try subtracting the divisor
    rem_sh   = {acc_q, a_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    quo_next = {a_q[WIDTH-2:0], ~rem_diff[WIDTH]};
`endif
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          dz_d  = 1'b0;
          cnt_d = '0;
          a_d   = A_ALUC;
          b_d   = B_ALUC;
          acc_d = '0;
          if (SELECTOR == 4'b0010) begin
            state_d = S_MUL;
`ifdef ALU_DIV_EN
          end else if (SELECTOR == 4'b0011 && B_ALUC != '0) begin
            state_d = S_DIV;
          end else if (SELECTOR == 4'b0011) begin
            res_d   = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
`else
          end else if (SELECTOR == 4'b0011) begin
            // No divider built: quotient reads as zero, divide-by-zero still flagged
            res_d   = '0;
            dz_d    = (B_ALUC == '0);
            state_d = S_DONE;
`endif
          end else begin
            res_d   = simple_res;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          res_d   = mul_sum;
          state_d = S_DONE;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        acc_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        a_d   = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          res_d   = quo_next;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      res_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RESULTADO = res_q;
  assign DZ        = dz_q;
  assign ZF        = (res_q == '0);

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo at WIDTH=32: directed scenarios plus randomized ops.
// A monitor compares every valid output cycle against an arithmetic model.
module tb_alu_multiciclo;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          IN_VALID;
  logic          IN_READY;
  logic [W-1:0]  A_ALUC, B_ALUC;
  logic [3:0]    SELECTOR;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [W-1:0]  RESULTADO;
  logic          ZF, DZ;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  alu_multiciclo #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A_ALUC(A_ALUC), .B_ALUC(B_ALUC), .SELECTOR(SELECTOR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULTADO(RESULTADO), .ZF(ZF), .DZ(DZ)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the operation table
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic d, output int lat);
    longint unsigned prod;
    d = 1'b0;
    lat = 1;
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: begin prod = longint'(a) * longint'(b); r = prod[W-1:0]; lat = W + 1; end
      4'd3: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin r = '1; d = 1'b1; end
        else begin r = a / b; lat = W + 1; end
`else
        r = '0; d = (b == 0);
`endif
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~(a | b);
      4'd8: r = (a < b) ? 1 : 0;
      default: r = '0;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] r;
    logic         d;
    int           due;
    bit           seen;
  } exp_t;
  exp_t expq[$];

  // Monitor: checks outputs every cycle against outstanding expectations
  always @(negedge CLK) begin
    logic [W-1:0] r;
    logic d;
    int lat;
    exp_t e;
    if (!RST_N) begin
      expq.delete();
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_res", RESULTADO, 0);
      chk("rst_zf", ZF, 1);
      chk("rst_dz", DZ, 0);
    end else begin
      chk("in_ready", IN_READY, (expq.size() == 0));
      if (OUT_VALID) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", OUT_VALID, 0);
        end else begin
          if (!expq[0].seen) begin
            chk("latency", cyc, expq[0].due);
            expq[0].seen = 1;
          end
          chk("res", RESULTADO, expq[0].r);
          chk("zf", ZF, (expq[0].r == 0));
          chk("dz", DZ, expq[0].d);
          if (OUT_READY) void'(expq.pop_front());
        end
      end else if (expq.size() > 0) begin
        if (expq[0].seen) begin
          chk("valid_dropped", OUT_VALID, 1);
          void'(expq.pop_front());
        end else if (cyc == expq[0].due) begin
          chk("valid_on_time", OUT_VALID, 1);
        end
      end
      if (IN_VALID && IN_READY) begin
        model(SELECTOR, A_ALUC, B_ALUC, r, d, lat);
        e.r = r; e.d = d; e.due = cyc + lat; e.seen = 0;
        expq.push_back(e);
      end
    end
  end

  // One transaction; optional literal checks of result, DZ and latency
  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold, input bit lit,
                        input logic [W-1:0] er, input logic ed, input int el);
    int n;
    logic [W-1:0] r0;
    n = 0;
    while (!IN_READY && n < 200) begin @(posedge CLK); #1; n++; end
    if (!IN_READY) chk({nm, "_ready_timeout"}, IN_READY, 1);
    OUT_READY = (hold == 0);
    IN_VALID = 1'b1; SELECTOR = op; A_ALUC = a; B_ALUC = b;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A_ALUC = $urandom; B_ALUC = $urandom; SELECTOR = 4'($urandom);
    n = 1;
    while (!OUT_VALID && n < 100) begin
      @(posedge CLK); #1; n++;
      A_ALUC = $urandom; B_ALUC = $urandom;
    end
    if (!OUT_VALID) chk({nm, "_valid_timeout"}, OUT_VALID, 1);
    r0 = RESULTADO;
    if (lit) begin
      chk({nm, "_res"}, RESULTADO, er);
      chk({nm, "_dz"}, DZ, ed);
      chk({nm, "_lat"}, n, el);
    end
    for (int i = 0; i < hold; i++) begin
      IN_VALID = 1'b1; SELECTOR = 4'($urandom); A_ALUC = $urandom; B_ALUC = $urandom;
      @(posedge CLK); #1;
      chk({nm, "_hold_res"}, RESULTADO, r0);
      chk({nm, "_hold_in_ready"}, IN_READY, 0);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    if (lit) chk({nm, "_ready_after_take"}, IN_READY, 1);
    OUT_READY = 1'($urandom);
  endtask

  logic [W-1:0] swa, swb;
  logic [W-1:0] sw_exp [9];

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A_ALUC = '0; B_ALUC = '0; SELECTOR = '0;
    swa = 32'hF0F0F0F0; swb = 32'h0F0F0F0F;
    sw_exp[0] = 32'hFFFFFFFF; sw_exp[1] = 32'hE1E1E1E1; sw_exp[2] = 0; sw_exp[3] = 0;
    sw_exp[4] = 32'h0; sw_exp[5] = 32'hFFFFFFFF; sw_exp[6] = 32'hFFFFFFFF;
    sw_exp[7] = 32'h0; sw_exp[8] = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_zf", ZF, 1);
    chk("reset_res", RESULTADO, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Reset in the middle of a multiply aborts it
    IN_VALID = 1'b1; SELECTOR = 4'b0010; A_ALUC = 7; B_ALUC = 9;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    RST_N = 1'b0;
    #2;
    chk("abort_in_ready", IN_READY, 1);
    chk("abort_out_valid", OUT_VALID, 0);
    chk("abort_res", RESULTADO, 0);
    chk("abort_zf", ZF, 1);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    run_op("add_after_reset", 4'b0000, 2, 3, 0, 1, 5, 0, 1);

    // Single-cycle sweep on complementary patterns
    for (int k = 0; k < 9; k++) begin
      if (k == 2 || k == 3) run_op("sweep_long", 4'(k), swa, swb, 0, 0, 0, 0, 0);
      else run_op("sweep", 4'(k), swa, swb, 0, 1, sw_exp[k], 0, 1);
    end
    run_op("sub_zero", 4'b0001, 5, 5, 0, 1, 0, 0, 1);
    chk("sub_zero_zf", ZF, 1);
    run_op("add_wrap", 4'b0000, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 1);

    run_op("mul", 4'b0010, 32'h10000, 32'h10001, 0, 1, 32'h00010000, 0, 33);
`ifdef ALU_DIV_EN
    run_op("div", 4'b0011, 100, 7, 0, 1, 14, 0, 33);
    run_op("div_zero", 4'b0011, 100, 0, 0, 1, 32'hFFFFFFFF, 1, 1);
`else
    run_op("div_off", 4'b0011, 100, 7, 0, 1, 0, 0, 1);
    run_op("div_off_zero", 4'b0011, 100, 0, 0, 1, 0, 1, 1);
`endif
    run_op("backpressure", 4'b0110, 32'h1234, 32'h00FF, 5, 1, 32'h12CB, 0, 1);
    for (int k = 9; k < 16; k++) run_op("invalid_op", 4'(k), $urandom, $urandom, 0, 1, 0, 0, 1);

    // Randomized operations with random backpressure
    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: rb = $urandom_range(1, 15);
        2: rb = ra;
        default: rb = $urandom;
      endcase
      run_op("rand", 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3), 0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
    repeat (3) begin @(posedge CLK); #1; end
    chk("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end
endmodule
